// File: rtl/latch_bank_write_ctrl.sv
// Write controller and round-robin arbiter for a bank of 2**AW word latches.
// Every write is sequenced as data setup, enable open, then enable close with
// data hold, so no latch ever sees its d input move while its enable is high.
// Bank-wide clears are sequenced through the same state machine and take
// priority over pending writes.
//
// Handshake: a requester raises req with addr/wdata valid. The arbiter answers
// with a one-hot gnt that stays high for the whole transaction. Operands are
// captured at grant, so later changes to req/addr/wdata are ignored. done pulses
// for one cycle in the final (HOLD) cycle of the transaction. A requester must
// drop req in the cycle after done; if req is still high in the following IDLE,
// it is treated as a new request.
module latch_bank_write_ctrl #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int AW        = 3,
    parameter int EN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    input  logic                 clr_req,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 clr_done,
    output logic [DW-1:0]        lat_d,
    output logic [(1<<AW)-1:0]   lat_en,
    output logic                 lat_rstn,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int NW = 1 << AW;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    // An enable window of zero cycles would never open the latch.
    if (EN_CYCLES < 1) begin : g_bad_en_cycles
        $error("latch_bank_write_ctrl: EN_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            clr_pending_q, clr_pending_d;

    logic [NREQ-1:0] gnt_d, done_d;
    logic            clr_done_d, lat_rstn_d, busy_d;
    logic [DW-1:0]   lat_d_d;
    logic [NW-1:0]   lat_en_d;

    logic            found;
    logic [PW-1:0]   sel;
    int              idx;

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        clr_pending_d = clr_pending_q;
        gnt_d         = gnt;
        done_d        = '0;
        clr_done_d    = 1'b0;
        lat_d_d       = lat_d;
        lat_en_d      = '0;
        lat_rstn_d    = 1'b1;

        // A clear request arriving mid-transaction is remembered until IDLE.
        if (clr_req && state_q != IDLE) begin
            clr_pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (clr_req || clr_pending_q) begin
                    state_d       = CLEAR;
                    lat_rstn_d    = 1'b0;
                    clr_done_d    = 1'b1;
                    clr_pending_d = 1'b0;
                end else if (found) begin
                    state_d = SETUP;
                    gnt_d   = NREQ'(1) << sel;
                    ptr_d   = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    addr_d  = addr[sel*AW +: AW];
                    lat_d_d = wdata[sel*DW +: DW];
                end
            end
            SETUP: begin
                state_d  = OPEN;
                lat_en_d = NW'(1) << addr_q;
                cnt_d    = '0;
            end
            OPEN: begin
                if (cnt_q == CW'(EN_CYCLES - 1)) begin
                    state_d = HOLD;
                    done_d  = gnt;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    lat_en_d = lat_en;
                end
            end
            HOLD: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            addr_q        <= '0;
            cnt_q         <= '0;
            clr_pending_q <= 1'b0;
            gnt           <= '0;
            done          <= '0;
            clr_done      <= 1'b0;
            lat_d         <= '0;
            lat_en        <= '0;
            lat_rstn      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            clr_pending_q <= clr_pending_d;
            gnt           <= gnt_d;
            done          <= done_d;
            clr_done      <= clr_done_d;
            lat_d         <= lat_d_d;
            lat_en        <= lat_en_d;
            lat_rstn      <= lat_rstn_d;
            busy          <= busy_d;
        end
    end

    assign dbg_state = state_q;

    // Structural invariants of the write path.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
    a_en_onehot:  assert property (@(posedge clk) disable iff (!rstn) $onehot0(lat_en));
    a_en_in_open: assert property (@(posedge clk) disable iff (!rstn)
                                   (lat_en != '0) |-> (state_q == OPEN));
    a_done_gnt:   assert property (@(posedge clk) disable iff (!rstn)
                                   ((done & ~gnt) == '0));

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Directed bench for latch_bank_write_ctrl: one instance with the default
// enable window and one with a three-cycle window, fed from shared inputs.
module tb_latch_bank_write_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NW   = 1 << AW;

    // clock/reset
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic               clr_req;

    logic [NREQ-1:0] gnt, done, gnt3, done3;
    logic            clr_done, lat_rstn, busy, clr_done3, lat_rstn3, busy3;
    logic [DW-1:0]   lat_d, lat_d3;
    logic [NW-1:0]   lat_en, lat_en3;
    logic [2:0]      dbg_state, dbg_state3;

    int n_assert = 0;
    int n_fail   = 0;

    // expected transaction table for the contention test
    logic [AW-1:0] t_addr [NREQ];
    logic [DW-1:0] t_data [NREQ];
    int            order  [5];

    latch_bank_write_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .EN_CYCLES(1)) dut (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr), .wdata(wdata),
        .clr_req(clr_req), .gnt(gnt), .done(done), .clr_done(clr_done),
        .lat_d(lat_d), .lat_en(lat_en), .lat_rstn(lat_rstn), .busy(busy),
        .dbg_state(dbg_state)
    );

    latch_bank_write_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .EN_CYCLES(3)) dut3 (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr), .wdata(wdata),
        .clr_req(clr_req), .gnt(gnt3), .done(done3), .clr_done(clr_done3),
        .lat_d(lat_d3), .lat_en(lat_en3), .lat_rstn(lat_rstn3), .busy(busy3),
        .dbg_state(dbg_state3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    initial begin
        req     = '0;
        addr    = '0;
        wdata   = '0;
        clr_req = 1'b0;

        // ---- reset state
        tick();
        tick();
        chk("rst_gnt",      32'(gnt),       32'h0);
        chk("rst_done",     32'(done),      32'h0);
        chk("rst_clr_done", 32'(clr_done),  32'h0);
        chk("rst_lat_en",   32'(lat_en),    32'h0);
        chk("rst_lat_d",    32'(lat_d),     32'h0);
        chk("rst_lat_rstn", 32'(lat_rstn),  32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_state",    32'(dbg_state), 32'h0);
        rstn = 1'b1;
        tick();
        chk("rel_lat_rstn", 32'(lat_rstn),  32'h1);

        // ---- single write: req[2], addr 5, data A5 (both window lengths)
        req = 4'b0100;
        set_op(2, 3'd5, 8'hA5);
        tick();                                      // cycle 1: SETUP
        chk("sw_c1_gnt",    32'(gnt),    32'h4);
        chk("sw_c1_lat_d",  32'(lat_d),  32'hA5);
        chk("sw_c1_lat_en", 32'(lat_en), 32'h0);
        chk("sw_c1_busy",   32'(busy),   32'h1);
        chk("e3_c1_gnt",    32'(gnt3),   32'h4);
        chk("e3_c1_lat_d",  32'(lat_d3), 32'hA5);
        tick();                                      // cycle 2: OPEN
        chk("sw_c2_lat_en", 32'(lat_en), 32'h20);
        chk("sw_c2_done",   32'(done),   32'h0);
        chk("e3_c2_lat_en", 32'(lat_en3), 32'h20);
        tick();                                      // cycle 3: HOLD
        chk("sw_c3_lat_en", 32'(lat_en), 32'h0);
        chk("sw_c3_done",   32'(done),   32'h4);
        chk("sw_c3_gnt",    32'(gnt),    32'h4);
        chk("sw_c3_lat_d",  32'(lat_d),  32'hA5);
        chk("e3_c3_lat_en", 32'(lat_en3), 32'h20);
        chk("e3_c3_done",   32'(done3),  32'h0);
        req = 4'b0000;
        tick();                                      // cycle 4
        chk("sw_c4_busy",   32'(busy),   32'h0);
        chk("sw_c4_gnt",    32'(gnt),    32'h0);
        chk("sw_c4_done",   32'(done),   32'h0);
        chk("e3_c4_lat_en", 32'(lat_en3), 32'h20);
        chk("e3_c4_done",   32'(done3),  32'h0);
        tick();                                      // cycle 5
        chk("e3_c5_lat_en", 32'(lat_en3), 32'h0);
        chk("e3_c5_done",   32'(done3),  32'h4);
        chk("e3_c5_lat_d",  32'(lat_d3), 32'hA5);
        tick();                                      // cycle 6
        chk("e3_c6_busy",   32'(busy3),  32'h0);
        chk("e3_c6_gnt",    32'(gnt3),   32'h0);

        // ---- reset pulse to bring the pointer back to 0
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // ---- contention: all four requesting, distinct addresses
        t_addr[0] = 3'd1; t_data[0] = 8'h10;
        t_addr[1] = 3'd3; t_data[1] = 8'h21;
        t_addr[2] = 3'd6; t_data[2] = 8'h32;
        t_addr[3] = 3'd7; t_data[3] = 8'h43;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        for (int i = 0; i < NREQ; i++) set_op(i, t_addr[i], t_data[i]);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();                                  // SETUP
            chk("rr_gnt",    32'(gnt),    32'(1 << order[k]));
            chk("rr_lat_d",  32'(lat_d),  32'(t_data[order[k]]));
            tick();                                  // OPEN
            chk("rr_lat_en", 32'(lat_en), 32'(1 << t_addr[order[k]]));
            tick();                                  // HOLD
            chk("rr_done",   32'(done),   32'(1 << order[k]));
            tick();                                  // IDLE
            chk("rr_idle",   32'(busy),   32'h0);
        end
        req = 4'b0000;

        // ---- clear while busy: pointer now at 1, requesters 1 and 3 waiting
        req = 4'b1010;
        tick();
        chk("cl_gnt1",      32'(gnt),    32'h2);
        tick();
        chk("cl_lat_en1",   32'(lat_en), 32'h08);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("cl_done1",     32'(done),   32'h2);
        req = 4'b1000;
        tick();
        chk("cl_idle_gnt",  32'(gnt),    32'h0);
        chk("cl_idle_rstn", 32'(lat_rstn), 32'h1);
        tick();
        chk("cl_lat_rstn",  32'(lat_rstn), 32'h0);
        chk("cl_clr_done",  32'(clr_done), 32'h1);
        chk("cl_state",     32'(dbg_state), 32'h4);
        chk("cl_lat_en",    32'(lat_en),   32'h0);
        chk("cl_gnt_none",  32'(gnt),      32'h0);
        tick();
        chk("cl_after_rstn", 32'(lat_rstn), 32'h1);
        chk("cl_after_cd",   32'(clr_done), 32'h0);
        tick();
        chk("cl_gnt3",      32'(gnt),    32'h8);
        chk("cl_lat_d3",    32'(lat_d),  32'h43);
        tick();
        chk("cl_lat_en3",   32'(lat_en), 32'h80);
        tick();
        chk("cl_done3",     32'(done),   32'h8);
        req = 4'b0000;
        tick();

        // ---- reset in the middle of OPEN
        req = 4'b0001;
        tick();
        chk("ro_gnt",       32'(gnt),    32'h1);
        tick();
        chk("ro_lat_en",    32'(lat_en), 32'h02);
        rstn = 1'b0;
        tick();
        chk("ro_r_lat_en",  32'(lat_en),   32'h0);
        chk("ro_r_gnt",     32'(gnt),      32'h0);
        chk("ro_r_lat_rstn", 32'(lat_rstn), 32'h0);
        chk("ro_r_done",    32'(done),     32'h0);
        chk("ro_r_busy",    32'(busy),     32'h0);
        rstn = 1'b1;
        req  = 4'b0000;
        tick();
        chk("ro_rel_rstn",  32'(lat_rstn), 32'h1);
        chk("ro_rel_state", 32'(dbg_state), 32'h0);
        chk("ro_rel_done",  32'(done),     32'h0);

        // ---- pointer back at 0: requesters 0 and 1 both ask, 0 wins
        req = 4'b0011;
        tick();
        chk("ptr0_gnt",     32'(gnt),    32'h1);

        // ---- operand changes after grant are ignored
        set_op(0, 3'd0, 8'h00);
        req = 4'b0000;
        tick();
        chk("op_lat_en",    32'(lat_en), 32'h02);
        chk("op_lat_d",     32'(lat_d),  32'h10);
        tick();
        chk("op_done",      32'(done),   32'h1);
        chk("op_lat_d_hold", 32'(lat_d), 32'h10);
        tick();
        chk("op_idle",      32'(busy),   32'h0);
        chk("op_lat_d_idle", 32'(lat_d), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
